// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified RAM arbiter: requester tags and byte-offset width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_IF    = 2'd1,
    SRC_DM    = 2'd2,
    SRC_FLASH = 2'd3
  } mem_src_t;

  // Byte address bits dropped when forming a RAM word address.
  localparam int BYTE_OFS = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req[0] is fetch, req[1] is data.
// The priority pointer only moves when a grant is actually issued (advance=1).
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio_dm_q = 1 means req[1] wins the next tie; reset gives req[0] the first tie.
  logic prio_dm_q;
  logic prio_dm_d;

  // Grant selection and pointer update.
  always_comb begin
    gnt       = 2'b00;
    prio_dm_d = prio_dm_q;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_dm_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0]) begin
      prio_dm_d = 1'b1;
    end else if (gnt[1]) begin
      prio_dm_d = 1'b0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_dm_q <= 1'b0;
    end else begin
      prio_dm_q <= prio_dm_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port unified program/data RAM.
// Flash programming writes have absolute priority and bypass reset; fetch and
// data ports share the remaining cycles round-robin.
// Optional build macro: MEM_ARB_MISALIGN_CHK_EN enables the sticky misalignment flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RAM_AW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flash_en,
  input  logic [WIDTH-1:0]  flash_addr,
  input  logic [WIDTH-1:0]  flash_data,
  input  logic              if_req,
  input  logic [WIDTH-1:0]  if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WIDTH-1:0]  if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [WIDTH-1:0]  dm_addr,
  input  logic [WIDTH-1:0]  dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [WIDTH-1:0]  dm_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata,
  output logic              err_misaligned
);

  logic             arb_adv;
  logic [1:0]       arb_gnt;
  logic [WIDTH-1:0] sel_addr;
  logic             unused_addr_bits;
  mem_src_t         resp_src_q;
  mem_src_t         resp_src_d;

  // Core ports only compete when no flash write is present and reset is released.
  assign arb_adv = rst_n & ~flash_en;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({dm_req, if_req}),
    .advance (arb_adv),
    .gnt     (arb_gnt)
  );

  assign if_gnt = arb_gnt[0];
  assign dm_gnt = arb_gnt[1];

  // RAM port mux: flash first, then whichever core port was granted.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    sel_addr  = '0;
    if (flash_en) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_wdata = flash_data;
      sel_addr  = flash_addr;
    end else if (if_gnt) begin
      ram_en    = 1'b1;
      sel_addr  = if_addr;
    end else if (dm_gnt) begin
      ram_en    = 1'b1;
      ram_we    = dm_we;
      ram_wdata = dm_wdata;
      sel_addr  = dm_addr;
    end
  end

  // Word address; upper bits wrap modulo RAM depth and byte offset is ignored.
  assign ram_addr         = sel_addr[RAM_AW+BYTE_OFS-1:BYTE_OFS];
  assign unused_addr_bits = ^{sel_addr[WIDTH-1:RAM_AW+BYTE_OFS], sel_addr[BYTE_OFS-1:0]};

  // Tag the read that will come back from RAM next cycle.
  always_comb begin
    resp_src_d = SRC_NONE;
    if (if_gnt) begin
      resp_src_d = SRC_IF;
    end else if (dm_gnt && !dm_we) begin
      resp_src_d = SRC_DM;
    end
  end

  // Response tag register; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_src_q <= SRC_NONE;
    end else begin
      resp_src_q <= resp_src_d;
    end
  end

  assign if_rvalid = (resp_src_q == SRC_IF);
  assign dm_rvalid = (resp_src_q == SRC_DM);
  assign if_rdata  = ram_rdata;
  assign dm_rdata  = ram_rdata;

`ifdef MEM_ARB_MISALIGN_CHK_EN
  logic err_q;
  logic err_d;

  // Sticky flag for any granted core access with a non-word-aligned address.
  always_comb begin
    err_d = err_q;
    if (if_gnt && (if_addr[BYTE_OFS-1:0] != '0)) begin
      err_d = 1'b1;
    end
    if (dm_gnt && (dm_addr[BYTE_OFS-1:0] != '0)) begin
      err_d = 1'b1;
    end
  end

  // Misalignment flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_misaligned = err_q;
`else
  assign err_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

  localparam int WIDTH  = 32;
  localparam int RAM_AW = 9;
`ifdef MEM_ARB_MISALIGN_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              flash_en;
  logic [WIDTH-1:0]  flash_addr;
  logic [WIDTH-1:0]  flash_data;
  logic              if_req;
  logic [WIDTH-1:0]  if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [WIDTH-1:0]  if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [WIDTH-1:0]  dm_addr;
  logic [WIDTH-1:0]  dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [WIDTH-1:0]  dm_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [WIDTH-1:0]  ram_rdata;
  logic              err_misaligned;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WIDTH(WIDTH), .RAM_AW(RAM_AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flash_en       (flash_en),
    .flash_addr     (flash_addr),
    .flash_data     (flash_data),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_gnt         (if_gnt),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_gnt         (dm_gnt),
    .dm_rvalid      (dm_rvalid),
    .dm_rdata       (dm_rdata),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .err_misaligned (err_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: no reset, synchronous write and 1-cycle read.
  logic [WIDTH-1:0] mem [0:(1<<RAM_AW)-1];
  initial ram_rdata = '0;
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flash_en = 1'b0; flash_addr = '0; flash_data = '0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    // 1: flash write during reset, then fetch it back
    #2;
    flash_en = 1'b1; flash_addr = 32'h0; flash_data = 32'h02802783;
    #1;
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
    chk("rst_err", {31'b0, err_misaligned}, 32'd0);
    chk("rst_flash_we", {31'b0, ram_we}, 32'd1);
    chk("rst_flash_en", {31'b0, ram_en}, 32'd1);
    chk("rst_flash_addr", {23'b0, ram_addr}, 32'd0);
    chk("rst_flash_wdata", ram_wdata, 32'h02802783);
    tick();
    flash_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
    #1;
    chk("rst_if_gnt_forced0", {31'b0, if_gnt}, 32'd0);
    chk("rst_dm_gnt_forced0", {31'b0, dm_gnt}, 32'd0);
    chk("rst_ram_en_idle", {31'b0, ram_en}, 32'd0);
    dm_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("t1_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("t1_ram_addr", {23'b0, ram_addr}, 32'd0);
    chk("t1_ram_we", {31'b0, ram_we}, 32'd0);
    tick();
    if_req = 1'b0;
    #1;
    chk("t1_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h02802783);
    chk("t1_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);

    // preload word 1 through flash
    flash_en = 1'b1; flash_addr = 32'h4; flash_data = 32'h11110004;
    tick();
    flash_en = 1'b0;

    // 4: data write then read-after-write
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd36; dm_wdata = 32'd5;
    #1;
    chk("t4_wr_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("t4_wr_ram_we", {31'b0, ram_we}, 32'd1);
    chk("t4_wr_ram_addr", {23'b0, ram_addr}, 32'd9);
    tick();
    dm_we = 1'b0;
    #1;
    chk("t4_wr_no_rvalid", {31'b0, dm_rvalid}, 32'd0);
    chk("t4_rd_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("t4_rd_ram_we", {31'b0, ram_we}, 32'd0);
    tick();
    dm_req = 1'b0;
    #1;
    chk("t4_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("t4_dm_rdata", dm_rdata, 32'd5);
    chk("t4_if_rvalid", {31'b0, if_rvalid}, 32'd0);

    // 2: both ports requesting for four cycles alternate IF, DM, IF, DM
    if_req = 1'b1; if_addr = 32'd4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd36;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2_if_gnt_%0d", k), {31'b0, if_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2_dm_gnt_%0d", k), {31'b0, dm_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk($sformatf("t2_if_rvalid_%0d", k), {31'b0, if_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk($sformatf("t2_dm_rvalid_%0d", k), {31'b0, dm_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("t2_rdata_%0d", k), if_rdata, (k % 2 == 1) ? 32'h11110004 : 32'd5);
      end
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    #1;
    chk("t2_last_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("t2_last_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("t2_last_dm_rdata", dm_rdata, 32'd5);

    // 3: flash collides with fetch to the same word; fetch retries and sees new data
    flash_en = 1'b1; flash_addr = 32'd8; flash_data = 32'hfef60ce3;
    if_req = 1'b1; if_addr = 32'd8;
    #1;
    chk("t3_if_gnt_blocked", {31'b0, if_gnt}, 32'd0);
    chk("t3_flash_we", {31'b0, ram_we}, 32'd1);
    chk("t3_flash_addr", {23'b0, ram_addr}, 32'd2);
    tick();
    flash_en = 1'b0;
    #1;
    chk("t3_if_gnt_retry", {31'b0, if_gnt}, 32'd1);
    chk("t3_no_rvalid_yet", {31'b0, if_rvalid}, 32'd0);
    tick();
    if_req = 1'b0;
    flash_en = 1'b1; flash_addr = 32'd12; flash_data = 32'h0000abcd;
    #1;
    chk("t3_if_rvalid_with_flash", {31'b0, if_rvalid}, 32'd1);
    chk("t3_if_rdata", if_rdata, 32'hfef60ce3);
    chk("t3_flash_we2", {31'b0, ram_we}, 32'd1);
    tick();
    flash_en = 1'b0;

    // address wrap: 0x808 maps to word 2
    if_req = 1'b1; if_addr = 32'h808;
    #1;
    chk("wrap_gnt", {31'b0, if_gnt}, 32'd1);
    chk("wrap_ram_addr", {23'b0, ram_addr}, 32'd2);
    tick();
    if_req = 1'b0;
    #1;
    chk("wrap_rdata", if_rdata, 32'hfef60ce3);

    // 5: reset pulse drops an in-flight response and restores IF tie priority
    if_req = 1'b1; if_addr = 32'd4;
    #1;
    chk("t5_if_gnt", {31'b0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    #1;
    rst_n = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd36;
    #1;
    chk("t5_rvalid_dropped", {31'b0, if_rvalid}, 32'd0);
    chk("t5_if_gnt_in_rst", {31'b0, if_gnt}, 32'd0);
    chk("t5_dm_gnt_in_rst", {31'b0, dm_gnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t5_no_rvalid_after", {31'b0, if_rvalid | dm_rvalid}, 32'd0);
    chk("t5_tie_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("t5_tie_dm_gnt", {31'b0, dm_gnt}, 32'd0);
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    #1;
    chk("t5_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("t5_if_rdata", if_rdata, 32'h11110004);
    chk("t5_err_clear", {31'b0, err_misaligned}, 32'd0);

    // 6: misaligned fetch reads word 1; flag depends on build
    if_req = 1'b1; if_addr = 32'h6;
    #1;
    chk("t6_gnt", {31'b0, if_gnt}, 32'd1);
    chk("t6_ram_addr", {23'b0, ram_addr}, 32'd1);
    tick();
    if_req = 1'b0;
    #1;
    chk("t6_rdata", if_rdata, 32'h11110004);
    chk("t6_err", {31'b0, err_misaligned}, {31'b0, ERR_EXP});
    tick();
    tick();
    chk("t6_err_sticky", {31'b0, err_misaligned}, {31'b0, ERR_EXP});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
